// File: rtl/wb_arbiter_if.sv
// Writeback bundle: ALU and load results in, reservations in, register-file writes out.
// Pure wiring, no latency of its own.
// Handshakes are valid/ready; the writeback side never stalls its register-file outputs.
interface wb_arbiter_if #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int AW   = 4
) ();
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_addr;
    logic [NREG-1:0] wr_en;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] busy;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  iss_valid, iss_addr,
        output alu_ready, ld_ready, wr_en, wr_data, busy
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output iss_valid, iss_addr,
        input  alu_ready, ld_ready, wr_en, wr_data, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Generic circular FIFO with a head that can be read combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push_rdy depends only on the occupancy, so a full FIFO refuses a push even during a pop.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_rdy = (count < CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop & pop_vld;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Writeback arbiter: merges queued ALU results and load results into one register write per cycle.
// Latency: load 1 cycle to wr_en; ALU at least 2 cycles (FIFO entry, then pop to the output register).
// Backpressure: alu_ready drops when the FIFO is full; ld_ready drops once loads have starved the FIFO STARVE_MAX times.
module wb_arbiter #(
    parameter int DW         = 16,
    parameter int NREG       = 16,
    parameter int AW         = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    wb_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } res_t;

    res_t            alu_res, ld_res, head, win;
    logic            fifo_ne, fifo_pop, ld_win, win_vld;
    logic [SW-1:0]   starve_cnt;
    logic [NREG-1:0] win_onehot, iss_onehot;
    logic [NREG-1:0] wr_en_q, busy_q;
    logic [DW-1:0]   wr_data_q;

    assign alu_res = {bus.alu_addr, bus.alu_data};
    assign ld_res  = {bus.ld_addr, bus.ld_data};

    wb_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .push_vld (bus.alu_valid),
        .push_dat (alu_res),
        .push_rdy (bus.alu_ready),
        .pop      (fifo_pop),
        .pop_vld  (fifo_ne),
        .pop_dat  (head)
    );

    // Loads normally win; once they have won STARVE_MAX times over a waiting ALU result, the FIFO gets one turn.
    assign bus.ld_ready = !(fifo_ne && (starve_cnt == SW'(STARVE_MAX)));
    assign ld_win       = bus.ld_valid & bus.ld_ready;
    assign fifo_pop     = fifo_ne & ~ld_win;
    assign win_vld      = ld_win | fifo_ne;
    assign win          = ld_win ? ld_res : head;

    assign win_onehot = win_vld       ? (NREG'(1) << win.addr)      : '0;
    assign iss_onehot = bus.iss_valid ? (NREG'(1) << bus.iss_addr)  : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            starve_cnt <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            busy_q     <= '0;
        end else begin
            if (ld_win && fifo_ne)
                starve_cnt <= (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
            wr_en_q <= win_onehot;
            if (win_vld) wr_data_q <= win.data;
            // A reservation on the same edge as the write belongs to a newer instruction, so it survives.
            busy_q <= (busy_q & ~win_onehot) | iss_onehot;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus with a cycle-tagged scoreboard of expected register writes.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    wb_arbiter_if #(.DW(16), .NREG(16), .AW(4)) bus ();

    wb_arbiter #(
        .DW(16), .NREG(16), .AW(4), .FIFO_DEPTH(2), .STARVE_MAX(4)
    ) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_push(input int c, input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        e.cyc  = 32'(c);
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.iss_valid = 1'b0;
    endtask

    // Monitor: every write must match the entry tagged with the edge that registered it, and no tagged entry may be skipped.
    always @(negedge clk) begin
        int          idx;
        logic [15:0] oh;
        if (mon_en) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
                if (sb[i].cyc == 32'(cyc)) idx = i;
            if (idx >= 0) begin
                oh = 16'h1 << sb[idx].addr;
                check("sb_wr_en", 32'(bus.wr_en), 32'(oh));
                check("sb_wr_data", 32'(bus.wr_data), 32'(sb[idx].data));
                sb.delete(idx);
            end else if (bus.wr_en != '0) begin
                check("unexp_wr", 32'(bus.wr_en), 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        // Reset held with every valid asserted
        rst_b         = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = 16'hFFFF;
        bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd2; bus.ld_data  = 16'hEEEE;
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(bus.wr_en), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_wr_data", 32'(bus.wr_data), 32'h0);
        idle_inputs();
        rst_b = 1'b1;
        #1;
        check("rel_alu_ready", 32'(bus.alu_ready), 32'h1);
        check("rel_ld_ready", 32'(bus.ld_ready), 32'h1);
        mon_en = 1'b1;
        tick();

        // Single ALU beat: written on the edge after the push
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 16'hA5A5;
        check("alu_ready", 32'(bus.alu_ready), 32'h1);
        tick(); e = cyc;
        sb_push(e + 1, 4'd3, 16'hA5A5);
        bus.alu_valid = 1'b0;
        check("alu_no_bypass", 32'(bus.wr_en), 32'h0);
        tick();
        check("alu_wr_en", 32'(bus.wr_en), 32'h0008);
        tick();
        check("alu_idle", 32'(bus.wr_en), 32'h0);

        // Collision: load first, ALU one cycle later
        bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd5; bus.ld_data  = 16'h1234;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 16'hBEEF;
        tick(); e = cyc;
        sb_push(e, 4'd5, 16'h1234);
        sb_push(e + 1, 4'd7, 16'hBEEF);
        idle_inputs();
        check("col_r5", 32'(bus.wr_en), 32'h0020);
        tick();
        check("col_r7", 32'(bus.wr_en), 32'h0080);
        tick();

        // Full FIFO and load starvation limit
        bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd2; bus.ld_data  = 16'h1000;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = 16'hA001;
        tick(); e = cyc;
        sb_push(e, 4'd2, 16'h1000);
        sb_push(e + 5, 4'd1, 16'hA001);
        bus.alu_data = 16'hA002; bus.ld_data = 16'h1001;
        check("fill_alu_ready", 32'(bus.alu_ready), 32'h1);
        tick();
        sb_push(e + 1, 4'd2, 16'h1001);
        sb_push(e + 6, 4'd1, 16'hA002);
        bus.alu_data = 16'hA003;
        check("full_stall", 32'(bus.alu_ready), 32'h0);
        for (int i = 2; i <= 4; i++) begin
            bus.ld_data = 16'h1000 + 16'(i);
            check("starve_ld_ready", 32'(bus.ld_ready), 32'h1);
            tick();
            sb_push(e + i, 4'd2, 16'h1000 + 16'(i));
            bus.alu_valid = 1'b0;
        end
        check("starve_ld_block", 32'(bus.ld_ready), 32'h0);
        bus.ld_data = 16'h1005;
        tick();
        check("starve_ld_back", 32'(bus.ld_ready), 32'h1);
        bus.ld_valid = 1'b0;
        tick();
        tick();

        // Scoreboard set, clear, and same-edge set-over-clear
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd9;
        tick();
        bus.iss_valid = 1'b0;
        check("busy_set", 32'(bus.busy), 32'h0200);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd9; bus.alu_data = 16'h9999;
        tick(); e = cyc;
        sb_push(e + 1, 4'd9, 16'h9999);
        bus.alu_valid = 1'b0;
        check("busy_hold", 32'(bus.busy), 32'h0200);
        tick();
        check("busy_clr", 32'(bus.busy), 32'h0);
        check("busy_clr_wr", 32'(bus.wr_en), 32'h0200);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd9; bus.alu_data = 16'h9A9A;
        tick(); e = cyc;
        sb_push(e + 1, 4'd9, 16'h9A9A);
        bus.alu_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd9;
        tick();
        bus.iss_valid = 1'b0;
        check("busy_same_edge", 32'(bus.busy), 32'h0200);
        tick();

        // Reset mid-operation with two queued ALU entries
        bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd4;  bus.ld_data  = 16'h4444;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd10; bus.alu_data = 16'hB001;
        tick(); e = cyc;
        sb_push(e, 4'd4, 16'h4444);
        bus.alu_data = 16'hB002; bus.ld_data = 16'h4445;
        tick();
        sb_push(e + 1, 4'd4, 16'h4445);
        idle_inputs();
        check("mid_full", 32'(bus.alu_ready), 32'h0);
        @(negedge clk);
        #1;
        rst_b = 1'b0;
        #2;
        check("mid_rst_wr_en", 32'(bus.wr_en), 32'h0);
        rst_b = 1'b1;
        #1;
        check("mid_fifo_empty", 32'(bus.alu_ready), 32'h1);
        check("mid_busy", 32'(bus.busy), 32'h0);
        repeat (4) tick();
        check("mid_no_write", 32'(bus.wr_en), 32'h0);
        check("mid_busy_after", 32'(bus.busy), 32'h0);
        check("sb_drained", 32'(sb.size()), 32'h0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
